// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_CTRL_W = 2;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One entry of the pipeline stage: valid + data + ctrl with load/clear.
// Control bits are zeroed on clear so an invalid slot never carries live ctrl.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      ctrl_d  = ld_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Elastic valid/ready pipeline stage with 1-entry skid buffer and flush.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
`ifdef PIPE_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  pipe_state_e state_q, state_d;

  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data, main_ld_data;
  logic [CTRL_W-1:0] skid_ctrl, main_ld_ctrl;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
      state_d  = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_xfer) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain path is possible
          if (out_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  assign main_ld_data = main_from_skid ? skid_data : in_data;
  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (main_clr),
    .load    (main_load),
    .ld_data (main_ld_data),
    .ld_ctrl (main_ld_ctrl),
    .valid   (out_valid),
    .data    (out_data),
    .ctrl    (out_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (skid_clr),
    .load    (skid_load),
    .ld_data (in_data),
    .ld_ctrl (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

  assign in_ready = !skid_valid;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // cleared by reset only; flush deliberately leaves the count intact
  always_ff @(posedge clk) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs (stall counter checks
// compiled in when PIPE_STALL_CNT_EN is defined).
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock edge; outputs are sampled 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;

    // reset
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b1;
    step();

    // streaming 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_ctrl  = CW'(i);
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data",  64'(out_data),  64'(i));
      check("stream_ctrl",  64'(out_ctrl),  64'(i % 4));
      check("stream_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", 64'(out_valid), 64'd0);
    check("stream_drain_ctrl",  64'(out_ctrl),  64'd0);

    // back-pressure: 0xA then 0xB into a stalled stage
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; in_ctrl = 2'b01;
    step();
    check("bp_first_data",  64'(out_data), 64'hA);
    check("bp_first_ready", 64'(in_ready), 64'd1);
    in_data = 32'hB; in_ctrl = 2'b10;
    step();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_full_data",  64'(out_data), 64'hA);
    in_valid = 1'b0; in_data = 32'hDEAD; in_ctrl = 2'b11;
    step();
    check("bp_hold_data",  64'(out_data), 64'hA);
    check("bp_hold_ctrl",  64'(out_ctrl), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_rel_valid", 64'(out_valid), 64'd1);
    check("bp_rel_data",  64'(out_data),  64'hB);
    check("bp_rel_ctrl",  64'(out_ctrl),  64'd2);
    check("bp_rel_ready", 64'(in_ready),  64'd1);
    step();
    check("bp_empty_valid", 64'(out_valid), 64'd0);
    check("bp_empty_ctrl",  64'(out_ctrl),  64'd0);

    // flush while TWO, with a ctrl=11 entry offered in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC; in_ctrl = 2'b01;
    step();
    in_data = 32'hD;
    step();
    check("fl_pre_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; in_data = 32'hE; in_ctrl = 2'b11;
    step();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ctrl",  64'(out_ctrl),  64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("fl_post_valid", 64'(out_valid), 64'd0);
    check("fl_post_ctrl",  64'(out_ctrl),  64'd0);

    // bubble: ctrl bits without in_valid must not appear
    out_ready = 1'b1; in_valid = 1'b0; in_ctrl = 2'b11; in_data = 32'h55;
    step(); step();
    check("bub_valid", 64'(out_valid), 64'd0);
    check("bub_ctrl",  64'(out_ctrl),  64'd0);

`ifdef PIPE_STALL_CNT_EN
    rst = 1'b0;
    step();
    check("sc_rst", 64'(stall_cnt), 64'd0);
    rst = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7; in_ctrl = 2'b01;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("sc_five", 64'(stall_cnt), 64'd5);
    // output is delivered during the flush cycle, so no stall is counted
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("sc_after_flush", 64'(stall_cnt), 64'd5);
    check("sc_flush_valid", 64'(out_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
